// File: rtl/riscv_lsu.sv
// riscv_lsu -- RV32 load/store unit between the core's ALU and data memory.
//
// Decodes funct3 into byte enables, replicates store data across byte lanes,
// sign/zero-extends load data, and runs a req/gnt/rvalid handshake to dmem
// while stalling the core. Illegal funct3, bus timeout and (optionally)
// misalignment complete the access with rsp_fault_o instead of touching dmem.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   -> LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 fault.
//   undefined -> no misalign fault; halfword ignores addr[0], word ignores
//                addr[1:0].
//
// Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   req_valid_i/req_ready_o       core op handshake (accepted when both high)
//   req_we_i, req_funct3_i        1=store/0=load, RV32 LB..LHU / SB..SW code
//   req_addr_i, req_wdata_i       byte address, rs2 store data
//   stall_o                       ~req_ready_o, freezes PC / writeback
//   rsp_valid_o, rsp_fault_o      one-cycle completion pulse, fault qualifier
//   rsp_rdata_o                   extended load data (0 for stores/faults)
//   dmem_req_o/dmem_gnt_i         memory request, held until granted
//   dmem_we_o, dmem_be_o          write enable, byte enables
//   dmem_addr_o, dmem_wdata_o     word address, lane-replicated store data
//   dmem_rvalid_i, dmem_rdata_i   read data valid / write ack, raw read word
module riscv_lsu #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            req_ready_o,
  output logic            stall_o,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_fault_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  // Request captured on acceptance; pure data, so no reset needed.
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic [3:0]        be_q, be_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic accept, illegal, misalign, tmo_hit;

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = 4'b0011 << {a[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [1:0] sz, input logic [XLEN-1:0] d);
    case (sz)
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                  input logic [XLEN-1:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = lane[1] ? raw[31:16] : raw[15:0];
    case (f3)
      3'b000:  load_extend = {{(XLEN-8){b[7]}}, b};
      3'b001:  load_extend = {{(XLEN-16){h[15]}}, h};
      3'b100:  load_extend = {{(XLEN-8){1'b0}}, b};
      3'b101:  load_extend = {{(XLEN-16){1'b0}}, h};
      default: load_extend = raw;
    endcase
  endfunction

  assign accept  = (state_q == S_IDLE) && req_valid_i;
  assign illegal = req_we_i ? (req_funct3_i > 3'b010)
                            : (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                    (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  // Completion wins over timeout when both land in the same cycle.
  assign tmo_hit = (cnt_q >= TMO_LAST);

  always_comb begin
    we_d    = we_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      we_d    = req_we_i;
      f3_d    = req_funct3_i;
      lane_d  = req_addr_i[1:0];
      be_d    = store_be(req_funct3_i[1:0], req_addr_i[1:0]);
      addr_d  = {req_addr_i[XLEN-1:2], 2'b00};
      wdata_d = store_data(req_funct3_i[1:0], req_wdata_i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          cnt_d   = '0;
          rdata_d = '0;
          fault_d = illegal || misalign;
          state_d = (illegal || misalign) ? S_RESP : S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rvalid_i && (state_q == S_WAIT || dmem_gnt_i)) begin
          rdata_d = we_q ? '0 : load_extend(f3_q, lane_q, dmem_rdata_i);
          state_d = S_RESP;
        end else if (tmo_hit) begin
          fault_d = 1'b1;
          state_d = S_RESP;
        end else if (state_q == S_REQ && dmem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    we_q    <= we_d;
    f3_q    <= f3_d;
    lane_q  <= lane_d;
    be_q    <= be_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Outputs decode directly from flops; bus fields are zero outside REQ.
  assign req_ready_o  = (state_q == S_IDLE);
  assign stall_o      = ~req_ready_o;
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_fault_o  = rsp_valid_o && fault_q;
  assign rsp_rdata_o  = rsp_valid_o ? rdata_q : '0;
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = dmem_req_o && we_q;
  assign dmem_be_o    = dmem_req_o ? be_q : 4'b0000;
  assign dmem_addr_o  = dmem_req_o ? addr_q : '0;
  assign dmem_wdata_o = dmem_req_o ? wdata_q : '0;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu -- randomized bench for riscv_lsu with a transaction-level
// reference model (expected timing, bus fields and load result computed with
// plain arithmetic from the op, grant delay and rvalid delay).
module tb_riscv_lsu;
  localparam int TMO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        req_ready_o, stall_o, rsp_valid_o, rsp_fault_o;
  logic [31:0] rsp_rdata_o;
  logic        dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;

  int n_checks = 0;
  int n_errors = 0;

  riscv_lsu #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .stall_o(stall_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_fault_o(rsp_fault_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_illegal(input bit we, input int f3);
    if (we) return f3 >= 3;
    return f3 == 3 || f3 == 6 || f3 == 7;
  endfunction

  function automatic bit m_misalign(input int f3, input int a);
`ifdef LSU_MISALIGN_CHECK_EN
    int sz = f3 % 4;
    return (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
`else
    return (f3 < 0) && (a < 0);
`endif
  endfunction

  function automatic logic [3:0] m_be(input int f3, input int a);
    case (f3 % 4)
      0:       return 4'(1 << (a % 4));
      1:       return ((a % 4) >= 2) ? 4'd12 : 4'd3;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] w);
    case (f3 % 4)
      0:       return (w & 32'hFF) * 32'h01010101;
      1:       return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input int f3, input int a, input logic [31:0] raw);
    logic [31:0] v;
    case (f3 % 4)
      0: begin
        v = (raw >> (8 * (a % 4))) & 32'hFF;
        if (f3 < 4 && v >= 128) v = v - 32'd256;
      end
      1: begin
        v = (raw >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        if (f3 < 4 && v >= 32768) v = v - 32'd65536;
      end
      default: v = raw;
    endcase
    return v;
  endfunction

  // Starts and ends at a negedge with the DUT idle. g = request cycles before
  // grant (0 = immediate), r = cycles from grant to rvalid (0 = same cycle).
  task automatic run_op(input bit we, input int f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int g, input int r);
    bit          imm_fault, exp_fault, req_exp;
    int          a, tc, rsp_t;
    logic [31:0] exp_rd;
    a         = int'(addr[1:0]);
    imm_fault = m_illegal(we, f3) || m_misalign(f3, a);
    tc        = 1 + g + r;
    rsp_t     = imm_fault ? 1 : ((tc <= TMO) ? tc + 1 : TMO + 1);
    exp_fault = imm_fault || tc > TMO;
    exp_rd    = (we || exp_fault) ? 32'd0 : m_load(f3, a, rdata);

    check_eq("ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i   = 1'b1;
    req_we_i      = we;
    req_funct3_i  = 3'(f3);
    req_addr_i    = addr;
    req_wdata_i   = wdata;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'($urandom % 2);
    dmem_rdata_i  = $urandom;

    for (int t = 1; t <= rsp_t; t++) begin
      @(negedge clk_i);
      req_exp = !imm_fault && t <= 1 + g && t <= TMO;
      check_eq("dmem_req", {31'd0, dmem_req_o}, {31'd0, req_exp});
      check_eq("stall", {31'd0, stall_o}, 32'd1);
      check_eq("rsp_valid", {31'd0, rsp_valid_o}, {31'd0, t == rsp_t});
      if (req_exp) begin
        check_eq("dmem_addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
        check_eq("dmem_we", {31'd0, dmem_we_o}, {31'd0, we});
        if (we) begin
          check_eq("dmem_be", {28'd0, dmem_be_o}, {28'd0, m_be(f3, a)});
          check_eq("dmem_wdata", dmem_wdata_o, m_wdata(f3, wdata));
        end
      end
      if (t == rsp_t) begin
        check_eq("rsp_fault", {31'd0, rsp_fault_o}, {31'd0, exp_fault});
        check_eq("rsp_rdata", rsp_rdata_o, exp_rd);
      end
      // Busy-time noise on the core side must not be accepted.
      req_valid_i   = 1'($urandom % 2);
      req_we_i      = 1'($urandom % 2);
      req_funct3_i  = 3'($urandom % 8);
      req_addr_i    = $urandom;
      req_wdata_i   = $urandom;
      dmem_gnt_i    = req_exp && t == 1 + g;
      if (!imm_fault && t == tc) begin
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
      end else begin
        dmem_rvalid_i = (t < 1 + g) ? 1'($urandom % 2) : 1'b0;
        dmem_rdata_i  = $urandom;
      end
    end
    @(negedge clk_i);
    check_eq("ready_after", {31'd0, req_ready_o}, 32'd1);
    check_eq("rsp_after", {31'd0, rsp_valid_o}, 32'd0);
    req_valid_i   = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
  endtask

  initial begin
    bit          we;
    int          f3, g, r;
    logic [31:0] addr;

    #2;
    check_eq("rst_ready", {31'd0, req_ready_o}, 32'd1);
    check_eq("rst_stall", {31'd0, stall_o}, 32'd0);
    check_eq("rst_rsp", {31'd0, rsp_valid_o}, 32'd0);
    check_eq("rst_fault", {31'd0, rsp_fault_o}, 32'd0);
    check_eq("rst_rdata", rsp_rdata_o, 32'd0);
    check_eq("rst_dreq", {31'd0, dmem_req_o}, 32'd0);
    check_eq("rst_dwe", {31'd0, dmem_we_o}, 32'd0);
    check_eq("rst_be", {28'd0, dmem_be_o}, 32'd0);
    check_eq("rst_addr", dmem_addr_o, 32'd0);
    check_eq("rst_wdata", dmem_wdata_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_op(0, 2, 32'h104, 32'h0, 32'hDEADBEEF, 0, 1);   // LW
    run_op(0, 0, 32'h103, 32'h0, 32'h80112233, 0, 1);   // LB
    run_op(0, 4, 32'h103, 32'h0, 32'h80112233, 0, 1);   // LBU
    run_op(0, 5, 32'h102, 32'h0, 32'h80112233, 0, 1);   // LHU
    run_op(0, 1, 32'h102, 32'h0, 32'h80112233, 0, 0);   // LH, gnt+rvalid together
    run_op(1, 0, 32'h101, 32'hA5, 32'h0, 0, 1);         // SB
    run_op(1, 1, 32'h102, 32'h1234, 32'h0, 0, 1);       // SH
    run_op(1, 2, 32'h100, 32'hCAFEF00D, 32'h0, 0, 2);   // SW
    run_op(0, 2, 32'h104, 32'h0, 32'h12345678, 3, 1);   // grant withheld
    run_op(0, 2, 32'h104, 32'h0, 32'h12345678, 0, 99);  // no rvalid -> timeout
    run_op(1, 2, 32'h108, 32'h55AA55AA, 32'h0, 99, 0);  // no grant -> timeout
    run_op(0, 2, 32'h106, 32'h0, 32'hA1B2C3D4, 0, 1);   // misaligned LW
    run_op(0, 3, 32'h100, 32'h0, 32'h0, 0, 1);          // illegal load
    run_op(1, 3, 32'h100, 32'h0, 32'h0, 0, 1);          // illegal store

    // Reset while waiting for rvalid: back to idle, no response afterwards.
    req_valid_i  = 1'b1;
    req_we_i     = 1'b0;
    req_funct3_i = 3'b010;
    req_addr_i   = 32'h200;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    dmem_gnt_i  = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    check_eq("mid_stall", {31'd0, stall_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_ready", {31'd0, req_ready_o}, 32'd1);
    check_eq("mid_rst_rsp", {31'd0, rsp_valid_o}, 32'd0);
    @(negedge clk_i);
    rst_ni        = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0;
      check_eq("post_rst_rsp", {31'd0, rsp_valid_o}, 32'd0);
      check_eq("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
    end

    for (int i = 0; i < 200; i++) begin
      we   = 1'($urandom % 2);
      f3   = int'($urandom % 8);
      addr = ($urandom % 4 == 0) ? $urandom : (32'h100 | ($urandom % 16));
      g    = ($urandom % 8 == 0) ? 13 + int'($urandom % 6) : int'($urandom % 4);
      r    = ($urandom % 8 == 0) ? 13 + int'($urandom % 6) : int'($urandom % 4);
      run_op(we, f3, addr, $urandom, $urandom, g, r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
